fsub_pipe: RTL and testbench

//  Pipelined IEEE-754 single-precision subtractor, y = x1 - x2, round-to-nearest-even.

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/fsub_norm_round.sv | 80 ++++++++
 rtl/fsub_pipe.sv | 143 ++++++++++++++
 tb/tb_fsub_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the binary32 FPU datapaths.
//   float_t : {s, e[7:0], m[22:0]} view of a single-precision word
//   s1_t    : align-stage payload (aligned mantissas, effective op, specials)
//   s2_t    : add-stage payload (raw 28-bit sum, effective op, specials)
package fpu_pkg;

  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam int          MANT_W    = 27;
  localparam logic [4:0]  SHIFT_SAT = 5'd26;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } float_t;

  // Mantissa layout: [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant_l;
    logic [MANT_W-1:0] mant_s;
    logic              eff_sub;
    logic              special;
    logic [31:0]       spec_y;
  } s1_t;

  typedef struct packed {
    logic            sign;
    logic [7:0]      exp;
    logic [MANT_W:0] mant;
    logic            eff_sub;
    logic            special;
    logic [31:0]     spec_y;
  } s2_t;

endpackage

// File: rtl/fsub_norm_round.sv
// Combinational normalise / round-to-nearest-even / range check for fsub_pipe.
//   sign, exp   : sign and exponent of the larger-magnitude operand
//   mant[27:0]  : raw sum {carry, hidden, fraction, G, R, S}
//   eff_sub     : operation was an effective subtraction
//   special     : result is the precomputed spec_y
//   y, ovf      : packed binary32 result and overflow flag
module fsub_norm_round
  import fpu_pkg::*;
(
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [27:0] mant,
  input  logic        eff_sub,
  input  logic        special,
  input  logic [31:0] spec_y,
  output logic [31:0] y,
  output logic        ovf
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] c;
    logic       found;
    c     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      c = c + 5'd1;
      end
    end
    return c;
  endfunction

  // n excludes the hidden bit: [25:3] fraction, [2] G, [1] R, [0] S.
  // Returns {carry, fraction}; carry means the fraction wrapped to zero.
  function automatic logic [23:0] rne(input logic [25:0] n);
    logic inc;
    inc = n[2] && (n[1] || n[0] || n[3]);
    return {1'b0, n[25:3]} + {23'd0, inc};
  endfunction

  logic [4:0]        lz;
  logic [25:0]       n;
  logic signed [9:0] e_n;
  logic signed [9:0] e_r;
  logic [23:0]       r;

  always_comb begin
    y   = 32'd0;
    ovf = 1'b0;
    lz  = lzc27(mant[26:0]);
    if (mant[27]) begin
      // Carry out: shift right one, dropped bit folds into sticky.
      n   = {mant[26:2], mant[1] | mant[0]};
      e_n = $signed({2'b00, exp}) + 10'sd1;
    end else begin
      // Shifting only the bits below the hidden position is enough; the
      // hidden bit lands at [26] and is implied.
      n   = mant[25:0] << lz;
      e_n = $signed({2'b00, exp}) - $signed({5'd0, lz});
    end
    r   = rne(n);
    e_r = e_n + $signed({9'd0, r[23]});

    if (special) begin
      y = spec_y;
    end else if (mant == 28'd0) begin
      // Exact cancellation gives +0; only (-0)+(-0) keeps the sign.
      y = {sign & ~eff_sub, 31'd0};
    end else if (e_n <= 10'sd0) begin
      y = {sign, 31'd0};
    end else if (e_r >= 10'sd255) begin
      y   = {sign, EXP_MAX, 23'd0};
      ovf = 1'b1;
    end else begin
      y = {sign, e_r[7:0], r[22:0]};
    end
  end

endmodule

// File: rtl/fsub_pipe.sv
// Pipelined binary32 subtractor y = x1 - x2, round-to-nearest-even.
//   clk, rstn            : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (x1 minuend, x2 subtrahend)
//   out_valid / out_ready: result handshake (y, ovf)
// Three valid-tagged registers: align -> p0, add -> p1, normalise/round -> p2.
// Only the valid bits are reset; y/ovf are forced to zero while out_valid=0.
module fsub_pipe
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  function automatic logic [4:0] sat_shift(input logic [7:0] d);
    return (d > {3'd0, SHIFT_SAT}) ? SHIFT_SAT : d[4:0];
  endfunction

  float_t      a, b;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        sa, sb, a_big;
  logic [22:0] ma, mb;
  logic [7:0]  el, es;
  logic [26:0] ml_ext, ms_ext;
  logic [52:0] ms_sh;

  s1_t         s1_d, s1_p0;
  s2_t         s2_d, s2_p1;
  logic [31:0] y_d, y_p2;
  logic        ovf_d, ovf_p2;

  logic        vld_p0, vld_p1, vld_p2;
  logic        adv1, adv2, adv3;

  assign a = float_t'(x1);
  assign b = float_t'(x2);

  // ---- S1: negate x2, flush denormals, pick larger, align smaller ----
  always_comb begin
    s1_d   = '0;
    a_nan  = (a.e == EXP_MAX) && (a.m != 23'd0);
    b_nan  = (b.e == EXP_MAX) && (b.m != 23'd0);
    a_inf  = (a.e == EXP_MAX) && (a.m == 23'd0);
    b_inf  = (b.e == EXP_MAX) && (b.m == 23'd0);
    sa     = a.s;
    sb     = ~b.s;
    ma     = (a.e == 8'd0) ? 23'd0 : a.m;
    mb     = (b.e == 8'd0) ? 23'd0 : b.m;
    a_big  = {a.e, ma} >= {b.e, mb};
    if (a_big) begin
      el     = a.e;
      es     = b.e;
      ml_ext = {|a.e, ma, 3'b000};
      ms_ext = {|b.e, mb, 3'b000};
    end else begin
      el     = b.e;
      es     = a.e;
      ml_ext = {|b.e, mb, 3'b000};
      ms_ext = {|a.e, ma, 3'b000};
    end
    // The low 26 bits catch everything shifted past the sticky position.
    ms_sh = {ms_ext, 26'd0} >> sat_shift(el - es);

    s1_d.sign    = a_big ? sa : sb;
    s1_d.exp     = el;
    s1_d.mant_l  = ml_ext;
    s1_d.mant_s  = {ms_sh[52:27], ms_sh[26] | (|ms_sh[25:0])};
    s1_d.eff_sub = sa ^ sb;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s1_d.special = 1'b1;
      s1_d.spec_y  = QNAN;
    end else if (a_inf) begin
      s1_d.special = 1'b1;
      s1_d.spec_y  = {sa, EXP_MAX, 23'd0};
    end else if (b_inf) begin
      s1_d.special = 1'b1;
      s1_d.spec_y  = {sb, EXP_MAX, 23'd0};
    end
  end

  // A stage can load when it is empty or its content moves on this cycle.
  assign adv3     = !vld_p2 || out_ready;
  assign adv2     = !vld_p1 || adv3;
  assign adv1     = !vld_p0 || adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv1) vld_p0 <= in_valid;
      if (adv2) vld_p1 <= vld_p0;
      if (adv3) vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) s1_p0 <= s1_d;
    if (adv2 && vld_p0)   s2_p1 <= s2_d;
    if (adv3 && vld_p1) begin
      y_p2   <= y_d;
      ovf_p2 <= ovf_d;
    end
  end

  // ---- S2: add or subtract aligned mantissas (large - small >= 0) ----
  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_p0.sign;
    s2_d.exp     = s1_p0.exp;
    s2_d.eff_sub = s1_p0.eff_sub;
    s2_d.special = s1_p0.special;
    s2_d.spec_y  = s1_p0.spec_y;
    if (s1_p0.eff_sub) s2_d.mant = {1'b0, s1_p0.mant_l} - {1'b0, s1_p0.mant_s};
    else               s2_d.mant = {1'b0, s1_p0.mant_l} + {1'b0, s1_p0.mant_s};
  end

  // ---- S3: normalise, round, range check ----
  fsub_norm_round u_norm (
    .sign    (s2_p1.sign),
    .exp     (s2_p1.exp),
    .mant    (s2_p1.mant),
    .eff_sub (s2_p1.eff_sub),
    .special (s2_p1.special),
    .spec_y  (s2_p1.spec_y),
    .y       (y_d),
    .ovf     (ovf_d)
  );

  assign out_valid = vld_p2;
  assign y         = vld_p2 ? y_p2 : 32'd0;
  assign ovf       = vld_p2 ? ovf_p2 : 1'b0;

endmodule

// File: tb/tb_fsub_pipe.sv
module tb_fsub_pipe;

  logic        clk = 1'b0;
  logic        rstn, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [31:0] x1, x2, y;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] bp_a [6] = '{32'h40400000, 32'h40000000, 32'h3F800000,
                            32'h40800000, 32'h41000000, 32'h3F800000};
  logic [31:0] bp_b [6] = '{32'h3F800000, 32'h3F800000, 32'h3F800000,
                            32'h3F800000, 32'h40000000, 32'hBF800000};
  logic [31:0] bp_y [6] = '{32'h40000000, 32'h3F800000, 32'h00000000,
                            32'h40400000, 32'h40C00000, 32'h40000000};

  fsub_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_run++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    n_run++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    n_run++;
    assert (obs == exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ey, input logic eo, input bit chk_lat);
    int lat;
    bit seen;
    @(negedge clk);
    in_valid  = 1'b1;
    x1        = av;
    x2        = bv;
    out_ready = 1'b1;
    #1;
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check1({tag, "_seen"}, seen, 1'b1);
    if (chk_lat) check_int({tag, "_latency"}, lat, 3);
    check32({tag, "_y"}, y, ey);
    check1({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int          cyc, sent, got, stale;
    bit          acc;
    logic [31:0] held_y;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x1        = 32'd0;
    x2        = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_y", y, 32'd0);
    check1("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check1("rel_in_ready", in_ready, 1'b1);

    run_one("sub_3_1",      32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b1);
    run_one("cancel",       32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
    run_one("negz_posz",    32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    run_one("negz_negz",    32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
    run_one("exact_ulp",    32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 1'b0, 1'b0);
    run_one("tie_even",     32'h3F800000, 32'h33000000, 32'h3F800000, 1'b0, 1'b0);
    run_one("ovf_max",      32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0);
    run_one("inf_inf",      32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b0);
    run_one("inf_neginf",   32'h7F800000, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0);
    run_one("fin_inf",      32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0, 1'b0);
    run_one("nan_in",       32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);
    run_one("add_eff",      32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0);
    run_one("neg_result",   32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0, 1'b0);
    run_one("denorm_flush", 32'h00400000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0);
    run_one("underflow",    32'h80800001, 32'h80800000, 32'h80000000, 1'b0, 1'b0);
    run_one("carry_exact",  32'h4B7FFFFF, 32'hBF800000, 32'h4B800000, 1'b0, 1'b0);
    run_one("round_carry",  32'h4B7FFFFF, 32'hBF000000, 32'h4B800000, 1'b0, 1'b0);

    // Backpressure: consumer stalls for the first 5 cycles.
    cyc    = 0;
    sent   = 0;
    got    = 0;
    held_y = 32'd0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (sent < 6) begin
        in_valid = 1'b1;
        x1       = bp_a[sent];
        x2       = bp_b[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 3) begin
        check1("bp_in_ready_low", in_ready, 1'b0);
        check1("bp_out_valid_held", out_valid, 1'b1);
        held_y = y;
        check32("bp_held_y", held_y, bp_y[0]);
      end
      if (cyc == 4) check32("bp_y_stable", y, held_y);
      if (out_valid && out_ready) begin
        check32($sformatf("bp_order_%0d", got), y, bp_y[got]);
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    check_int("bp_results", got, 6);
    #1 in_valid = 1'b0;

    // Reset with three ops in flight.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x1       = bp_a[i];
      x2       = bp_b[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check1("mid_full", out_valid, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check1("mid_rst_out_valid", out_valid, 1'b0);
    check32("mid_rst_y", y, 32'd0);
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_int("mid_no_stale", stale, 0);
    check1("mid_in_ready", in_ready, 1'b1);
    run_one("post_rst", 32'h41000000, 32'h40000000, 32'h40C00000, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
